// File: rtl/ecpri_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecpri_pkg
//  Description : Shared definitions for the eCPRI payload RAM arbiter:
//                arbiter state encoding, requester indices and the default
//                burst cap.
//  Revision    : 1.0 - initial release
// ============================================================================
package ecpri_pkg;

    // Arbiter state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE   = 2'd0;  // no owner
    localparam state_t c_ST_XFER   = 2'd1;  // one beat per cycle for the owner
    localparam state_t c_ST_SWITCH = 2'd2;  // idle cycle after a preemption

    // Requester indices (also used as the owner select bit)
    localparam logic c_REQ_RX = 1'b0;       // rx write path
    localparam logic c_REQ_TX = 1'b1;       // tx read path

    // Beats per grant before a waiting requester forces a switch
    localparam int unsigned c_MAX_BURST_DEF = 16;

endpackage : ecpri_pkg
`default_nettype wire

// File: rtl/ecpri_arb_ctx.sv
`default_nettype none
// ============================================================================
//  Module      : ecpri_arb_ctx
//  Description : Transfer context of one requester: next RAM address,
//                bytes remaining and a "loaded" flag. Survives preemption,
//                is dropped on completion or abort.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_load         - capture i_start/i_len, set o_act
//                i_step         - one beat done: ptr+1 (wrapping), rem-1
//                i_clear        - forget the context
//                i_start, i_len - transfer start address / length in bytes
//                o_ptr, o_rem   - next address / bytes remaining
//                o_act          - context is loaded
//  Revision    : 1.0 - initial release
// ============================================================================
module ecpri_arb_ctx #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic                  i_clear,
    input  logic [ADDR_WIDTH-1:0] i_start,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic [ADDR_WIDTH-1:0] o_ptr,
    output logic [LEN_WIDTH-1:0]  o_rem,
    output logic                  o_act
);

    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic                  r_act;

    // Clear wins over load wins over step. The arbiter only loads an
    // inactive context and only clears an active one, so those never meet.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_ptr <= '0;
            r_rem <= '0;
            r_act <= 1'b0;
        end else if (i_load) begin
            r_ptr <= i_start;
            r_rem <= i_len;
            r_act <= 1'b1;
        end else if (i_step) begin
            r_ptr <= r_ptr + 1'b1;   // wraps modulo 2^ADDR_WIDTH
            r_rem <= r_rem - 1'b1;
        end
    end

    assign o_ptr = r_ptr;
    assign o_rem = r_rem;
    assign o_act = r_act;

endmodule : ecpri_arb_ctx
`default_nettype wire

// File: rtl/ecpri_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ecpri_mem_arb
//  Description : Round-robin sequencer sharing the single-port eCPRI payload
//                RAM between the rx write path (requester 0) and the tx read
//                path (requester 1). Bursts are capped at MAX_BURST beats
//                when the other side waits; a preempted transfer keeps its
//                context and resumes where it stopped.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                req_0/start_0/len_0/wdata_0 - rx write request
//                wr_ack_0, gnt_0, done_0     - rx write handshake/status
//                req_1/start_1/len_1         - tx read request
//                rdata_1, rvalid_1, gnt_1, done_1 - tx read data/status
//                ram_addr/ram_wdata/ram_we/ram_oe/ram_rdata - RAM port
//                busy                        - arbiter not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module ecpri_mem_arb
    import ecpri_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_BURST  = c_MAX_BURST_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    // requester 0: rx write path
    input  logic                  req_0,
    input  logic [ADDR_WIDTH-1:0] start_0,
    input  logic [LEN_WIDTH-1:0]  len_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    output logic                  wr_ack_0,
    output logic                  gnt_0,
    output logic                  done_0,
    // requester 1: tx read path
    input  logic                  req_1,
    input  logic [ADDR_WIDTH-1:0] start_1,
    input  logic [LEN_WIDTH-1:0]  len_1,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  rvalid_1,
    output logic                  gnt_1,
    output logic                  done_1,
    // payload RAM port
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy
);

    localparam int                c_BEAT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_MAX = c_BEAT_W'(MAX_BURST);

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t                r_state,     w_state_nxt;
    logic [1:0]            r_gnt,       w_gnt_nxt;        // {gnt_1, gnt_0}
    logic                  r_last_gnt,  w_last_gnt_nxt;
    logic [c_BEAT_W-1:0]   r_beat,      w_beat_nxt;
    logic [ADDR_WIDTH-1:0] r_ram_addr,  w_ram_addr_nxt;
    logic [DATA_WIDTH-1:0] r_ram_wdata, w_ram_wdata_nxt;
    logic                  r_ram_we,    w_ram_we_nxt;
    logic                  r_ram_oe,    w_ram_oe_nxt;
    logic [1:0]            r_done,      w_done_nxt;       // {done_1, done_0}
    logic                  r_rvalid_1;

    // ------------------------------------------------------------------
    // Per-requester contexts
    // ------------------------------------------------------------------
    logic [1:0]            w_req;
    logic [ADDR_WIDTH-1:0] w_start [2];
    logic [LEN_WIDTH-1:0]  w_len   [2];
    logic [ADDR_WIDTH-1:0] w_ptr   [2];
    logic [LEN_WIDTH-1:0]  w_rem   [2];
    logic [1:0]            w_act;
    logic [1:0]            w_load;
    logic [1:0]            w_step;
    logic [1:0]            w_clr;

    assign w_req      = {req_1, req_0};
    assign w_start[0] = start_0;
    assign w_start[1] = start_1;
    assign w_len[0]   = len_0;
    assign w_len[1]   = len_1;

    for (genvar g = 0; g < 2; g++) begin : g_ctx
        ecpri_arb_ctx #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .LEN_WIDTH  (LEN_WIDTH)
        ) u_ctx (
            .clk     (clk),
            .rst     (reset),
            .i_load  (w_load[g]),
            .i_step  (w_step[g]),
            .i_clear (w_clr[g]),
            .i_start (w_start[g]),
            .i_len   (w_len[g]),
            .o_ptr   (w_ptr[g]),
            .o_rem   (w_rem[g]),
            .o_act   (w_act[g])
        );
    end

    // Owner index is only meaningful in XFER, where exactly one gnt is set.
    logic w_own;
    logic w_pick;
    logic w_wr_ack_0;

    assign w_own = r_gnt[1];

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_last_gnt_nxt  = r_last_gnt;
        w_beat_nxt      = r_beat;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_ram_we_nxt    = 1'b0;
        w_ram_oe_nxt    = 1'b0;
        w_done_nxt      = 2'b00;
        w_load          = 2'b00;
        w_step          = 2'b00;
        // A loaded context whose requester has let go is an abort: drop it
        // silently, whether it is currently granted or parked by preemption.
        w_clr           = w_act & ~w_req;
        w_wr_ack_0      = 1'b0;
        w_pick          = 1'b0;

        case (r_state)
            c_ST_IDLE, c_ST_SWITCH: begin
                w_state_nxt = c_ST_IDLE;
                if (w_req != 2'b00) begin
                    // Both asking: the one not served last wins.
                    w_pick = (w_req == 2'b11) ? ~r_last_gnt : w_req[1];
                    w_gnt_nxt         = 2'b00;
                    w_gnt_nxt[w_pick] = 1'b1;
                    w_last_gnt_nxt    = w_pick;
                    w_beat_nxt        = '0;
                    w_state_nxt       = c_ST_XFER;
                    // A resumed transfer keeps its pointer and remainder.
                    w_load[w_pick]    = ~w_act[w_pick];
                end
            end

            c_ST_XFER: begin
                if (!w_req[w_own]) begin
                    // abort: context cleared by the default above, no done
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = c_ST_IDLE;
                end else if (w_rem[w_own] == '0) begin
                    // completion (also covers a zero-length request)
                    w_gnt_nxt         = 2'b00;
                    w_state_nxt       = c_ST_IDLE;
                    w_clr[w_own]      = 1'b1;
                    w_done_nxt[w_own] = 1'b1;
                end else if ((r_beat == c_BEAT_MAX) && w_req[~w_own]) begin
                    // preemption: park the context and give the other side a turn
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = c_ST_SWITCH;
                end else begin
                    w_ram_addr_nxt = w_ptr[w_own];
                    w_step[w_own]  = 1'b1;
                    if (r_beat != c_BEAT_MAX) begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                    if (w_own == c_REQ_TX) begin
                        w_ram_oe_nxt = 1'b1;
                    end else begin
                        w_ram_we_nxt    = 1'b1;
                        w_ram_wdata_nxt = wdata_0;
                        w_wr_ack_0      = 1'b1;
                    end
                end
            end

            default: begin
                w_gnt_nxt   = 2'b00;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_gnt       <= 2'b00;
            r_last_gnt  <= c_REQ_TX;   // requester 0 wins the first tie
            r_beat      <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_ram_oe    <= 1'b0;
            r_done      <= 2'b00;
            r_rvalid_1  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_last_gnt  <= w_last_gnt_nxt;
            r_beat      <= w_beat_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_oe    <= w_ram_oe_nxt;
            r_done      <= w_done_nxt;
            // RAM read latency is one cycle: data follows the strobe.
            r_rvalid_1  <= r_ram_oe;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_ack_0  = w_wr_ack_0 & ~reset;
    assign gnt_0     = r_gnt[0];
    assign gnt_1     = r_gnt[1];
    assign done_0    = r_done[0];
    assign done_1    = r_done[1];
    assign rdata_1   = ram_rdata;
    assign rvalid_1  = r_rvalid_1;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_we    = r_ram_we;
    assign ram_oe    = r_ram_oe;
    assign busy      = (r_state != c_ST_IDLE);

endmodule : ecpri_mem_arb
`default_nettype wire

// File: tb/tb_ecpri_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecpri_mem_arb
//  Description : Directed self-checking bench for ecpri_mem_arb with a
//                behavioural single-port RAM and output logs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ecpri_mem_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_0, req_1;
    logic [15:0] start_0, start_1;
    logic [7:0]  len_0, len_1;
    logic [7:0]  wdata_0;
    logic        wr_ack_0, gnt_0, done_0;
    logic [7:0]  rdata_1;
    logic        rvalid_1, gnt_1, done_1;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we, ram_oe;
    logic [7:0]  ram_rdata;
    logic        busy;

    ecpri_mem_arb #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (16),
        .LEN_WIDTH  (8),
        .MAX_BURST  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_0     (req_0),
        .start_0   (start_0),
        .len_0     (len_0),
        .wdata_0   (wdata_0),
        .wr_ack_0  (wr_ack_0),
        .gnt_0     (gnt_0),
        .done_0    (done_0),
        .req_1     (req_1),
        .start_1   (start_1),
        .len_1     (len_1),
        .rdata_1   (rdata_1),
        .rvalid_1  (rvalid_1),
        .gnt_1     (gnt_1),
        .done_1    (done_1),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    // ---------------- RAM model (1-cycle read latency) ----------------
    logic [7:0]  mem [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_oe) ram_rdata <= mem[ram_addr];
    end

    // ---------------- write-data source, advanced by wr_ack_0 --------
    logic [7:0] wbuf [0:63];
    logic [5:0] widx;
    logic       ack_q;
    assign wdata_0 = wbuf[widx];

    always @(posedge clk) begin
        #1;
        if (reset) widx = 6'd0;
        else if (ack_q) widx = widx + 6'd1;
    end

    // ---------------- monitor ----------------
    logic [15:0] wlog_a [$];
    logic [7:0]  wlog_d [$];
    logic [7:0]  rlog   [$];
    int          gseq   [$];
    int d0_cnt = 0, d1_cnt = 0, oe_cnt = 0, ovl = 0, weoe = 0, adj = 0;
    logic prev_g0 = 1'b0, prev_g1 = 1'b0;

    always @(negedge clk) begin
        ack_q = wr_ack_0;
        if (ram_we) begin
            wlog_a.push_back(ram_addr);
            wlog_d.push_back(ram_wdata);
        end
        if (ram_oe)   oe_cnt++;
        if (rvalid_1) rlog.push_back(rdata_1);
        if (done_0)   d0_cnt++;
        if (done_1)   d1_cnt++;
        if (gnt_0 && gnt_1)  ovl++;
        if (ram_we && ram_oe) weoe++;
        if (gnt_0 && !prev_g0) begin gseq.push_back(0); if (prev_g1) adj++; end
        if (gnt_1 && !prev_g1) begin gseq.push_back(1); if (prev_g0) adj++; end
        prev_g0 = gnt_0;
        prev_g1 = gnt_1;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Wait for done of one requester and release its request in that cycle.
    task automatic wait_done(input bit which, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (which ? done_1 : done_0) begin
                seen = 1'b1;
                if (which) req_1 = 1'b0; else req_0 = 1'b0;
                break;
            end
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_writes(input int target, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wlog_a.size() >= target) begin ok = 1'b1; break; end
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    int wb, rb, gs, d0b, d1b, ob, adjb;
    logic [15:0] exp_wrap [4];

    initial begin
        reset = 1'b1; req_0 = 1'b0; req_1 = 1'b0;
        start_0 = '0; start_1 = '0; len_0 = '0; len_1 = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        ack_q = 1'b0; widx = '0; ram_rdata = '0;
        for (int i = 0; i < 64; i++) wbuf[i] = 8'h00;

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        check_eq("rst_gnt",    32'({gnt_1, gnt_0}), 32'd0);
        check_eq("rst_strobe", 32'({ram_we, ram_oe}), 32'd0);
        check_eq("rst_busy",   32'(busy), 32'd0);
        check_eq("rst_addr",   32'(ram_addr), 32'd0);
        check_eq("rst_done",   32'({done_1, done_0, rvalid_1}), 32'd0);

        // ---- single write burst: 4 bytes at 0x0100 ----
        sync();
        for (int i = 0; i < 4; i++) wbuf[i] = 8'hA1 + 8'(i);
        start_0 = 16'h0100; len_0 = 8'd4;
        wb = wlog_a.size(); d0b = d0_cnt;
        req_0 = 1'b1;
        @(negedge clk);
        check_eq("t1_gnt_before_edge", 32'(gnt_0), 32'd0);
        @(negedge clk);
        check_eq("t1_gnt", 32'(gnt_0), 32'd1);
        check_eq("t1_wr_ack", 32'(wr_ack_0), 32'd1);
        wait_done(1'b0, "t1_done");
        sync();
        check_eq("t1_nwr", 32'(wlog_a.size() - wb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_addr", 32'(wlog_a[wb+i]), 32'h0100 + 32'(i));
            check_eq("t1_data", 32'(wlog_d[wb+i]), 32'hA1 + 32'(i));
        end
        check_eq("t1_done_cnt", 32'(d0_cnt - d0b), 32'd1);

        // ---- single read burst: 3 bytes at 0x0200 ----
        do_reset();
        preload(16'h0200, 8'h11);
        preload(16'h0201, 8'h22);
        preload(16'h0202, 8'h33);
        start_1 = 16'h0200; len_1 = 8'd3;
        rb = rlog.size();
        req_1 = 1'b1;
        wait_done(1'b1, "t2_done");
        check_eq("t2_done_rvalid", 32'(rvalid_1), 32'd1);
        check_eq("t2_done_rdata",  32'(rdata_1), 32'h33);
        sync();
        check_eq("t2_nrd", 32'(rlog.size() - rb), 32'd3);
        check_eq("t2_rd0", 32'(rlog[rb]),   32'h11);
        check_eq("t2_rd1", 32'(rlog[rb+1]), 32'h22);
        check_eq("t2_rd2", 32'(rlog[rb+2]), 32'h33);

        // ---- both requesting from reset, len 2 each ----
        wbuf[0] = 8'hB1; wbuf[1] = 8'hB2;
        start_0 = 16'h0300; len_0 = 8'd2;
        start_1 = 16'h0200; len_1 = 8'd2;
        req_0 = 1'b1; req_1 = 1'b1;
        gs = gseq.size(); adjb = adj; wb = wlog_a.size(); rb = rlog.size();
        do_reset();
        wait_done(1'b0, "t3_done0");
        wait_done(1'b1, "t3_done1");
        sync();
        check_eq("t3_ngrants", 32'(gseq.size() - gs), 32'd2);
        check_eq("t3_first",   32'(gseq[gs]),   32'd0);
        check_eq("t3_second",  32'(gseq[gs+1]), 32'd1);
        check_eq("t3_idle_gap", 32'(adj - adjb), 32'd0);
        check_eq("t3_wr1", 32'({wlog_a[wb+1], wlog_d[wb+1]}), 32'h0301B2);
        check_eq("t3_rd1", 32'(rlog[rb+1]), 32'h22);

        // ---- preemption: 40 writes, read of 2 raised mid-burst ----
        do_reset();
        for (int i = 0; i < 40; i++) wbuf[i] = 8'h60 + 8'(i);
        start_0 = 16'h0400; len_0 = 8'd40;
        wb = wlog_a.size(); rb = rlog.size(); d0b = d0_cnt;
        req_0 = 1'b1;
        wait_writes(wb + 5, "t4_beat5");
        start_1 = 16'h0200; len_1 = 8'd2;
        req_1 = 1'b1;
        wait_done(1'b1, "t4_done1");
        sync();
        check_eq("t4_wr_before_switch", 32'(wlog_a.size() - wb), 32'd16);
        check_eq("t4_nrd", 32'(rlog.size() - rb), 32'd2);
        check_eq("t4_rd0", 32'(rlog[rb]), 32'h11);
        wait_done(1'b0, "t4_done0");
        sync();
        check_eq("t4_nwr", 32'(wlog_a.size() - wb), 32'd40);
        check_eq("t4_resume_addr", 32'(wlog_a[wb+16]), 32'h0410);
        check_eq("t4_resume_data", 32'(wlog_d[wb+16]), 32'h70);
        check_eq("t4_last", 32'({wlog_a[wb+39], wlog_d[wb+39]}), 32'h042787);
        check_eq("t4_done_cnt", 32'(d0_cnt - d0b), 32'd1);

        // ---- address wrap ----
        do_reset();
        for (int i = 0; i < 4; i++) wbuf[i] = 8'hC1 + 8'(i);
        exp_wrap[0] = 16'hFFFE; exp_wrap[1] = 16'hFFFF;
        exp_wrap[2] = 16'h0000; exp_wrap[3] = 16'h0001;
        start_0 = 16'hFFFE; len_0 = 8'd4;
        wb = wlog_a.size();
        req_0 = 1'b1;
        wait_done(1'b0, "t5_done");
        sync();
        for (int i = 0; i < 4; i++)
            check_eq("t5_wrap_addr", 32'(wlog_a[wb+i]), 32'(exp_wrap[i]));

        // ---- zero-length request ----
        do_reset();
        start_0 = 16'h0600; len_0 = 8'd0;
        wb = wlog_a.size(); d0b = d0_cnt;
        req_0 = 1'b1;
        wait_done(1'b0, "t6_len0_done");
        sync();
        check_eq("t6_len0_nwr", 32'(wlog_a.size() - wb), 32'd0);
        check_eq("t6_len0_done_cnt", 32'(d0_cnt - d0b), 32'd1);

        // ---- abort of a read, then fresh request reloads start ----
        do_reset();
        start_1 = 16'h0200; len_1 = 8'd3;
        rb = rlog.size(); d1b = d1_cnt; ob = oe_cnt;
        req_1 = 1'b1;
        begin : oe_wait
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (ram_oe) begin seen = 1'b1; break; end
            end
            check_eq("t7_first_oe", 32'(seen), 32'd1);
        end
        req_1 = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t7_oe_off",  32'({gnt_1, ram_oe}), 32'd0);
        check_eq("t7_noe",     32'(oe_cnt - ob), 32'd1);
        check_eq("t7_no_done", 32'(d1_cnt - d1b), 32'd0);
        check_eq("t7_nrd",     32'(rlog.size() - rb), 32'd1);
        len_1 = 8'd2;
        rb = rlog.size();
        req_1 = 1'b1;
        wait_done(1'b1, "t7_redo_done");
        sync();
        check_eq("t7_reload_rd0", 32'(rlog[rb]),   32'h11);
        check_eq("t7_reload_rd1", 32'(rlog[rb+1]), 32'h22);

        // ---- reset in the middle of a write burst ----
        do_reset();
        start_0 = 16'h0500; len_0 = 8'd10;
        wb = wlog_a.size(); d0b = d0_cnt;
        req_0 = 1'b1;
        wait_writes(wb + 3, "t8_running");
        check_eq("t8_busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t8_rst_gnt", 32'({gnt_1, gnt_0}), 32'd0);
        check_eq("t8_rst_strobe", 32'({ram_we, ram_oe}), 32'd0);
        check_eq("t8_rst_ram", 32'({ram_addr, ram_wdata}), 32'd0);
        check_eq("t8_rst_busy", 32'(busy), 32'd0);
        req_0 = 1'b0;
        sync();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t8_no_done", 32'(d0_cnt - d0b), 32'd0);

        // ---- global invariants ----
        check_eq("gnt_overlap", 32'(ovl), 32'd0);
        check_eq("we_oe_overlap", 32'(weoe), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ecpri_mem_arb
`default_nettype wire
